// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data RAM behind the decoded load/store
// path. Stores commit in one cycle with byte enables. Loads return sign- or
// zero-extended data after LATENCY cycles, and busy stalls the pipeline
// while a load is outstanding.
module data_mem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  fun3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        misaligned
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'((LATENCY >= 2) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_NONE} size_t;

    // fun3[1:0] selects the access width; fun3[2] only matters for load extension
    function automatic size_t size_of(input logic [2:0] f);
        case (f[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            2'b10:   return SZ_W;
            default: return SZ_NONE;
        endcase
    endfunction

    function automatic logic mis_of(input size_t sz, input logic [1:0] lo);
        return ((sz == SZ_H) && lo[0]) || ((sz == SZ_W) && (lo != 2'b00));
    endfunction

    logic [31:0]   mem [DEPTH];

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [2:0]    fun3_q, fun3_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rdata_valid_q, rdata_valid_d;
    logic          misaligned_q, misaligned_d;

    size_t         st_size;
    logic          st_mis;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   wword;
    logic [AW-1:0] st_idx;

    logic [AW+1:0] ld_addr;
    logic [2:0]    ld_fun3;
    size_t         ld_size;
    logic          ld_mis;
    logic [31:0]   rd_word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   ld_data;
    logic          finish;

    logic          unused_addr_bits;

    // Upper address bits wrap away; keep them visibly consumed
    always_comb unused_addr_bits = ^addr[31:AW+2];

    // Store decode: lane enables and lane-replicated write data
    always_comb begin
        st_size = size_of(fun3);
        st_mis  = mis_of(st_size, addr[1:0]);
        st_idx  = addr[AW+1:2];
        we      = (state_q == IDLE) && store && (st_size != SZ_NONE) && !st_mis;
        be      = 4'b0000;
        wword   = wdata;
        case (st_size)
            SZ_B: begin
                be    = 4'b0001 << addr[1:0];
                wword = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
            end
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Load read path; with LATENCY=1 the read completes in the accept cycle,
    // so the live request is used there instead of the captured one
    always_comb begin
        ld_addr  = (state_q == IDLE) ? addr[AW+1:0] : addr_q;
        ld_fun3  = (state_q == IDLE) ? fun3 : fun3_q;
        ld_size  = size_of(ld_fun3);
        ld_mis   = mis_of(ld_size, ld_addr[1:0]);
        rd_word  = mem[ld_addr[AW+1:2]];
        byte_sel = rd_word[{ld_addr[1:0], 3'b000} +: 8];
        half_sel = ld_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (ld_size)
            SZ_B:    ld_data = ld_fun3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    ld_data = ld_fun3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            SZ_W:    ld_data = rd_word;
            default: ld_data = '0;
        endcase
        if (ld_mis) begin
            ld_data = '0;
        end
    end

    // Next-state logic for the load FSM and the registered output pulses
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        fun3_d        = fun3_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        misaligned_d  = 1'b0;
        finish        = 1'b0;
        case (state_q)
            IDLE: begin
                if (store) begin
                    misaligned_d = (st_size != SZ_NONE) && st_mis;
                end else if (load) begin
                    addr_d = addr[AW+1:0];
                    fun3_d = fun3;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                        finish  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (finish) begin
            rdata_valid_d = 1'b1;
            rdata_d       = ld_data;
            misaligned_d  = ld_mis;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            fun3_q        <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            fun3_q        <= fun3_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            misaligned_q  <= misaligned_d;
        end
    end

    // RAM write port with byte-lane enables; contents are not reset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[st_idx][i*8 +: 8] <= wword[i*8 +: 8];
                end
            end
        end
    end

    // busy is combinational in the accept cycle, state-driven while waiting
    always_comb busy = ((state_q == IDLE) && load && !store) || (state_q == WAIT);

    always_comb begin
        rdata_valid = rdata_valid_q;
        rdata       = rdata_q;
        misaligned  = misaligned_q;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder at the far end of the load/store path produced by the instruction decoders.
- Consumes the decoded Load/Store strobes, fun3 size code, effective address and store data.
- Owns a word-organised data RAM, applies byte enables on stores, and returns sign- or zero-extended load data after a programmable wait.
- Drives `busy` back to the decoder's load-suppress input (`load_signal_controller`) so the pipeline stalls while a load is outstanding.

Parameters:
DEPTH, 256, number of 32-bit words in the RAM; power of 2, minimum 4.
LATENCY, 2, load latency in cycles from request to rdata_valid; range 1..15.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
load  input  1  load request (decoded Load)
store  input  1  store request (decoded Store / mem_en)
fun3  input  3  size code: 000 b, 001 h, 010 w, 100 bu, 101 hu, 110 treated as w
addr  input  32  byte address (ALU result)
wdata  input  32  store data (rs2), low bytes used for sb/sh
busy  output  1  stall request to pipeline / decoder load suppress
rdata_valid  output  1  one-cycle pulse, rdata valid
rdata  output  32  extended load data
misaligned  output  1  one-cycle pulse on misaligned access

Behaviour:
- Word index is addr[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- Reset values: busy=0, rdata_valid=0, rdata=0, misaligned=0, internal counter=0. RAM contents are not reset.
- Reset asserted mid-load: the FSM returns to IDLE and no rdata_valid pulse is produced for the aborted load.
- Store handling:
  - Accepted only in IDLE, single cycle, never raises busy.
  - The write commits at the clock edge ending the request cycle.
  - sb writes byte lane addr[1:0] from wdata[7:0].
  - sh writes lanes {addr[1],0}/{addr[1],1} from wdata[15:0].
  - sw writes all four lanes.
- Load handling:
  - A load present in IDLE (with store=0) is accepted in that cycle, call it C0. addr and fun3 are captured at the end of C0.
  - busy is high in C0 through C0+LATENCY-1. busy is combinational in C0 (load & IDLE); in WAIT it is driven from state.
  - rdata and rdata_valid are registered; rdata_valid=1 and rdata is valid in cycle C0+LATENCY (state DONE), and busy=0 in that cycle.
  - LATENCY=1: IDLE goes directly to DONE. Otherwise WAIT counts LATENCY-2 down to 0, then goes to DONE.
  - DONE always returns to IDLE. A load still asserted in DONE is the completing instruction and is not re-accepted.
  - rdata holds its value until the next rdata_valid.
- Load extension:
  - lb and lh sign-extend; lbu and lhu zero-extend.
  - The byte or half is selected by addr[1:0] / addr[1].
- Misalignment:
  - Half access with addr[0]=1 is misaligned; word access with addr[1:0]!=0 is misaligned.
  - A misaligned store pulses misaligned in the request cycle+1 and does not write the RAM.
  - A misaligned load completes with normal timing, returns rdata=0, and pulses misaligned together with rdata_valid.
- Unsupported fun3 (011, 111): a store is ignored; a load returns 0. No misaligned pulse in either case.
- load and store both high: treated as a store; the load is ignored.
- store or load asserted in WAIT: ignored, since the pipeline is stalled.
- Read-after-write: a store at edge E followed by a load in the next cycle returns the new data.

Test Plan:
- Reset then sw addr=0x10 wdata=0xDEADBEEF; lw addr=0x10 with LATENCY=2 -> busy=1 for 2 cycles, rdata_valid pulse in cycle 3, rdata=0xDEADBEEF.
- sb addr=0x21 wdata=0x80 over word 0 at 0x20; lb 0x21 -> rdata=0xFFFFFF80; lbu 0x21 -> rdata=0x00000080; lw 0x20 -> 0x00008000.
- sh addr=0x32 wdata=0x8001; lh 0x32 -> 0xFFFF8001; lhu 0x32 -> 0x00008001; lh 0x30 -> 0x00000000.
- sw addr=0x41 -> misaligned pulse, RAM unchanged (lw 0x40 returns the prior value); lh addr=0x43 -> misaligned with rdata_valid, rdata=0.
- Back-to-back loads held asserted for LATENCY=3 -> each completes exactly once, busy pattern 1,1,1,0 repeating, no duplicate rdata_valid.
- Assert rst in the WAIT state of a load -> busy=0 and rdata_valid=0 immediately, no pulse afterwards. An addr=DEPTH*4+8 store aliases to word 2.
